// File: rtl/prf_free_list_pkg.sv
// Shared sizing, tag/pointer types and a pointer-offset helper for the PRF free list.
package prf_free_list_pkg;

    localparam int unsigned WAY       = 2;
    localparam int unsigned PRF_ENTRY = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned TAG_W     = $clog2(PRF_ENTRY);
    localparam int unsigned DEPTH     = PRF_ENTRY - ARCH_REGS;
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned PTR_W     = IDX_W + 1;
    localparam int unsigned OFS_W     = $clog2(WAY + 1);

    typedef logic [TAG_W-1:0] prf_tag_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Storage index of a wrap-bit pointer advanced by a per-slot offset.
    function automatic logic [IDX_W-1:0] ptr_idx(ptr_t base, logic [OFS_W-1:0] ofs);
        ptr_t p;
        p = base + PTR_W'(ofs);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/prf_free_list_if.sv
// Rename/commit-side interface of the PRF free list.
interface prf_free_list_if;
    import prf_free_list_pkg::*;

    logic [WAY-1:0]     alloc_req;
    logic               alloc_ready;
    prf_tag_t [WAY-1:0] alloc_tag;
    logic [WAY-1:0]     commit_en;
    prf_tag_t [WAY-1:0] commit_old_tag;
    logic               flush;
    logic [PTR_W-1:0]   free_count;

    modport master (
        output alloc_req, commit_en, commit_old_tag, flush,
        input  alloc_ready, alloc_tag, free_count
    );

    modport slave (
        input  alloc_req, commit_en, commit_old_tag, flush,
        output alloc_ready, alloc_tag, free_count
    );

endinterface

// File: rtl/prf_free_list_prefix_popcount.sv
// Exclusive prefix count over a WAY-wide mask: per-slot compaction offsets plus total.
module prf_free_list_prefix_popcount
    import prf_free_list_pkg::*;
(
    input  logic [WAY-1:0]            bits_i,
    output logic [WAY-1:0][OFS_W-1:0] offset_o,
    output logic [OFS_W-1:0]          total_o
);

    logic [OFS_W-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < WAY; i++) begin
            offset_o[i] = acc;
            acc         = acc + OFS_W'(bits_i[i]);
        end
    end

    assign total_o = acc;

endmodule

// File: rtl/prf_free_list.sv
// Circular free list of physical tags with a committed read pointer for one-cycle flush recovery.
module prf_free_list
    import prf_free_list_pkg::*;
(
    input logic            clk,
    input logic            rst,
    prf_free_list_if.slave fl_io
);

    prf_tag_t mem_q [DEPTH];
    ptr_t     head_q, head_d;
    ptr_t     rhead_q, rhead_d;
    ptr_t     tail_q, tail_d;

    logic [WAY-1:0][OFS_W-1:0] alloc_ofs;
    logic [WAY-1:0][OFS_W-1:0] commit_ofs;
    logic [OFS_W-1:0]          nalloc;
    logic [OFS_W-1:0]          nrel;
    logic [PTR_W-1:0]          free_count;
    logic                      alloc_ready;
    logic                      alloc_fire;

    prf_free_list_prefix_popcount u_alloc_pc (
        .bits_i   (fl_io.alloc_req),
        .offset_o (alloc_ofs),
        .total_o  (nalloc)
    );

    prf_free_list_prefix_popcount u_commit_pc (
        .bits_i   (fl_io.commit_en),
        .offset_o (commit_ofs),
        .total_o  (nrel)
    );

    assign free_count  = tail_q - head_q;
    assign alloc_ready = free_count >= PTR_W'(nalloc);
    assign alloc_fire  = (|fl_io.alloc_req) && alloc_ready && !fl_io.flush;

    assign fl_io.free_count  = free_count;
    assign fl_io.alloc_ready = alloc_ready;

    always_comb begin
        fl_io.alloc_tag = '0;
        for (int i = 0; i < WAY; i++) begin
            if (fl_io.alloc_req[i]) begin
                fl_io.alloc_tag[i] = mem_q[ptr_idx(head_q, alloc_ofs[i])];
            end
        end
    end

    // Every commit retires exactly one entry that head already consumed, so rhead tracks tail.
    always_comb begin
        tail_d  = tail_q + PTR_W'(nrel);
        rhead_d = rhead_q + PTR_W'(nrel);
        head_d  = head_q;
        if (fl_io.flush) begin
            head_d = rhead_d;
        end else if (alloc_fire) begin
            head_d = head_q + PTR_W'(nalloc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= ptr_t'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= prf_tag_t'(ARCH_REGS + i);
            end
        end else begin
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
            for (int i = 0; i < WAY; i++) begin
                if (fl_io.commit_en[i]) begin
                    mem_q[ptr_idx(tail_q, commit_ofs[i])] <= fl_io.commit_old_tag[i];
                end
            end
        end
    end

    for (genvar g = 0; g < WAY; g++) begin : g_tag_chk
        assert property (@(posedge clk) disable iff (rst)
            fl_io.commit_en[g] |-> (fl_io.commit_old_tag[g] != '0));
    end

    assert property (@(posedge clk) disable iff (rst)
        (32'(free_count) + 32'(nrel)) <= DEPTH);

endmodule

// File: tb/tb_prf_free_list.sv
// Self-checking bench for prf_free_list against a queue-based free/in-flight tag model.
module tb_prf_free_list;
    import prf_free_list_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    prf_tag_t free_q[$];
    prf_tag_t infl_q[$];

    prf_free_list_if fl ();

    prf_free_list dut (
        .clk   (clk),
        .rst   (rst),
        .fl_io (fl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [WAY-1:0] req, input logic [WAY-1:0] cen,
                         input prf_tag_t t0, input prf_tag_t t1, input logic fls);
        fl.alloc_req         = req;
        fl.commit_en         = cen;
        fl.commit_old_tag[0] = t0;
        fl.commit_old_tag[1] = t1;
        fl.flush             = fls;
    endtask

    // Free tags leave from the front; flush returns uncommitted allocations ahead of them.
    task automatic model_step();
        int nreq;
        bit fire;
        if (rst) begin
            free_q.delete();
            infl_q.delete();
            for (int i = 0; i < DEPTH; i++) free_q.push_back(prf_tag_t'(ARCH_REGS + i));
            return;
        end
        nreq = $countones(fl.alloc_req);
        fire = (nreq > 0) && (free_q.size() >= nreq) && !fl.flush;
        for (int i = 0; i < WAY; i++) begin
            if (fl.commit_en[i]) begin
                if (infl_q.size() > 0) void'(infl_q.pop_front());
                free_q.push_back(fl.commit_old_tag[i]);
            end
        end
        if (fl.flush) begin
            free_q = {infl_q, free_q};
            infl_q.delete();
        end else if (fire) begin
            for (int k = 0; k < nreq; k++) infl_q.push_back(free_q.pop_front());
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00, '0, '0, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(32)) begin
            errors++;
            $display("FAIL reset_free_count got %0d want 32", fl.free_count);
        end
        checks++;
        if (fl.alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_alloc_ready got %0b want 1", fl.alloc_ready);
        end
        checks++;
        if (fl.alloc_tag !== '0) begin
            errors++;
            $display("FAIL reset_idle_tags got %h want 0", fl.alloc_tag);
        end
    endtask

    task automatic test_drain();
        prf_tag_t e0, e1;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            drive(2'b11, 2'b00, '0, '0, 1'b0);
            #1;
            e0 = prf_tag_t'(32 + 2 * k);
            e1 = prf_tag_t'(33 + 2 * k);
            checks++;
            if (fl.alloc_tag[0] !== e0 || fl.alloc_tag[1] !== e1) begin
                errors++;
                $display("FAIL drain_tags step %0d got %0d,%0d want %0d,%0d",
                         k, fl.alloc_tag[0], fl.alloc_tag[1], e0, e1);
            end
            checks++;
            if (fl.free_count !== PTR_W'(32 - 2 * k)) begin
                errors++;
                $display("FAIL drain_count step %0d got %0d want %0d",
                         k, fl.free_count, 32 - 2 * k);
            end
            cycle();
        end
        drive(2'b01, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(0) || fl.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_state got count %0d ready %0b want 0 0",
                     fl.free_count, fl.alloc_ready);
        end
        cycle();
        checks++;
        if (fl.free_count !== PTR_W'(0)) begin
            errors++;
            $display("FAIL empty_hold got %0d want 0", fl.free_count);
        end
    endtask

    task automatic test_single_slot();
        do_reset();
        drive(2'b10, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.alloc_tag[1] !== prf_tag_t'(32) || fl.alloc_tag[0] !== prf_tag_t'(0)) begin
            errors++;
            $display("FAIL slot1_tags got %0d,%0d want 0,32", fl.alloc_tag[0], fl.alloc_tag[1]);
        end
        cycle();
        drive(2'b01, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(31)) begin
            errors++;
            $display("FAIL slot1_count got %0d want 31", fl.free_count);
        end
        checks++;
        if (fl.alloc_tag[0] !== prf_tag_t'(33)) begin
            errors++;
            $display("FAIL slot0_next got %0d want 33", fl.alloc_tag[0]);
        end
        cycle();
    endtask

    task automatic test_commit_no_bypass();
        do_reset();
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        repeat (16) cycle();
        drive(2'b11, 2'b11, prf_tag_t'(5), prf_tag_t'(9), 1'b0);
        #1;
        checks++;
        if (fl.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass_ready got %0b want 0", fl.alloc_ready);
        end
        cycle();
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.alloc_ready !== 1'b1 || fl.free_count !== PTR_W'(2)) begin
            errors++;
            $display("FAIL released_state got ready %0b count %0d want 1 2",
                     fl.alloc_ready, fl.free_count);
        end
        checks++;
        if (fl.alloc_tag[0] !== prf_tag_t'(5) || fl.alloc_tag[1] !== prf_tag_t'(9)) begin
            errors++;
            $display("FAIL released_tags got %0d,%0d want 5,9", fl.alloc_tag[0], fl.alloc_tag[1]);
        end
        cycle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        repeat (3) cycle();
        drive(2'b00, 2'b11, prf_tag_t'(1), prf_tag_t'(2), 1'b0);
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(26)) begin
            errors++;
            $display("FAIL pre_flush_count got %0d want 26", fl.free_count);
        end
        cycle();
        drive(2'b11, 2'b01, prf_tag_t'(7), '0, 1'b1);
        cycle();
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(32)) begin
            errors++;
            $display("FAIL post_flush_count got %0d want 32", fl.free_count);
        end
        checks++;
        if (fl.alloc_tag[0] !== prf_tag_t'(35) || fl.alloc_tag[1] !== prf_tag_t'(36)) begin
            errors++;
            $display("FAIL post_flush_tags got %0d,%0d want 35,36",
                     fl.alloc_tag[0], fl.alloc_tag[1]);
        end
        cycle();
    endtask

    task automatic test_random_wrap();
        logic [WAY-1:0] req, cen;
        logic           fls;
        prf_tag_t       exp_tag;
        int             rank;
        bit             exp_ready;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req = WAY'($urandom_range(3, 0));
            cen = WAY'($urandom_range(3, 0));
            if (infl_q.size() == 0) cen = 2'b00;
            else if (infl_q.size() == 1 && cen == 2'b11) cen = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
            fls = ($urandom_range(15, 0) == 0);
            drive(req, cen, prf_tag_t'($urandom_range(63, 1)), prf_tag_t'($urandom_range(63, 1)), fls);
            #1;
            exp_ready = free_q.size() >= $countones(req);
            checks++;
            if (fl.alloc_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %0b want %0b", c, fl.alloc_ready, exp_ready);
            end
            checks++;
            if (fl.free_count !== PTR_W'(free_q.size()) || free_q.size() > DEPTH) begin
                errors++;
                $display("FAIL rand_count cyc %0d got %0d want %0d",
                         c, fl.free_count, free_q.size());
            end
            rank = 0;
            for (int i = 0; i < WAY; i++) begin
                exp_tag = '0;
                if (req[i]) exp_tag = (rank < free_q.size()) ? free_q[rank] : fl.alloc_tag[i];
                checks++;
                if (fl.alloc_tag[i] !== exp_tag) begin
                    errors++;
                    $display("FAIL rand_tag cyc %0d slot %0d got %0d want %0d",
                             c, i, fl.alloc_tag[i], exp_tag);
                end
                if (req[i]) rank++;
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(2'b01, 2'b00, '0, '0, 1'b0);
        #1;
        checks++;
        if (fl.free_count !== PTR_W'(32)) begin
            errors++;
            $display("FAIL mid_reset_count got %0d want 32", fl.free_count);
        end
        checks++;
        if (fl.alloc_tag[0] !== prf_tag_t'(32)) begin
            errors++;
            $display("FAIL mid_reset_tag got %0d want 32", fl.alloc_tag[0]);
        end
        cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(2'b00, 2'b00, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        test_reset();
        test_drain();
        test_single_slot();
        test_commit_no_bypass();
        test_flush();
        test_random_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_free_list.md
Name: prf_free_list

Overview:
- Circular free list of physical register tags that feeds the rename stage.
- Dequeues up to WAY tags per cycle for renamed destinations.
- Enqueues up to WAY stale tags per cycle at commit. These are the same tags the PRF clears valid on through its free_en/free_tag inputs.
- Keeps a committed read pointer so that a branch-mispredict flush restores the list in one cycle.

Parameters:
- PRF_ENTRY, 64, number of physical registers; tag width TAG_W = $clog2(PRF_ENTRY).
- ARCH_REGS, 32, architectural registers; tags 0..ARCH_REGS-1 are mapped at reset, and tag 0 is permanently x0.
- WAY, 2, rename/commit width (from rv32i_types).
- DEPTH, PRF_ENTRY-ARCH_REGS, list capacity; must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_req  in  WAY  per-slot request for a new destination tag (rd != 0)
- alloc_ready  out  1  high when free_count >= popcount(alloc_req)
- alloc_tag  out  WAY x TAG_W  tag for each requesting slot; compacted so slot i gets entry head + popcount(alloc_req[i-1:0])
- commit_en  in  WAY  per-slot commit of an instruction that allocated a tag
- commit_old_tag  in  WAY x TAG_W  stale tag released by that commit
- flush  in  1  mispredict recovery
- free_count  out  $clog2(DEPTH)+1  number of tags currently allocatable

Behaviour:
- Storage is DEPTH x TAG_W.
- Pointers carry a wrap bit, ($clog2(DEPTH)+1 bits each):
  - head: speculative read pointer
  - rhead: committed read pointer
  - tail: write pointer
- free_count = tail - head. Full is tail - head == DEPTH; empty is tail == head.
- Reset:
  - entry i <= ARCH_REGS+i
  - head = rhead = 0
  - tail = DEPTH with the wrap bit set
  - free_count = DEPTH, alloc_ready = 1
- Allocation handshake:
  - Fires when |alloc_req && alloc_ready && !flush.
  - head advances by popcount(alloc_req).
  - alloc_tag is combinational from registered state (zero-latency peek).
  - Unrequested slots drive alloc_tag = 0.
  - If alloc_ready is low, nothing is dequeued and rename stalls the whole group; there are no partial allocations.
- Release:
  - Each commit_en[i] writes commit_old_tag[i] at tail + popcount(commit_en[i-1:0]).
  - tail advances by popcount(commit_en).
  - rhead advances by popcount(commit_en), because each committed allocating instruction consumed exactly one list entry.
  - Released tags become allocatable the next cycle; there is no same-cycle bypass.
- Flush:
  - head <= rhead_next, i.e. rhead after this cycle's commits are applied.
  - Allocation in the flush cycle is suppressed.
  - Commits in the flush cycle are honoured.
  - The cycle after flush has free_count = tail_next - rhead_next.
- Simultaneous allocate + release: both apply in the same cycle. free_count_next = free_count - nalloc + nrel.
- Overflow cannot occur because tail - rhead <= DEPTH by construction.
- Assertions:
  - Releasing tag 0 is a protocol violation.
  - commit_en while tail - rhead would exceed DEPTH is a protocol violation.
  - Non-contiguous commit_en (slot 1 without slot 0) is legal and compacted the same way.
- Wrap-around: pointer indices use the low $clog2(DEPTH) bits; the wrap bit disambiguates full from empty.
- Reset mid-operation restores the reset state; in-flight requests are dropped.

Decomposition:
- In rv32i_types: WAY, PRF_ENTRY, ARCH_REGS, typedef prf_tag_t (logic [TAG_W-1:0]), and the DEPTH localparam.
- One natural sub-module, prefix_popcount: a WAY-wide exclusive prefix count that produces per-slot offsets. It is instantiated twice, once for alloc and once for commit.
- The pointer and storage logic stays in prf_free_list.

Test Plan:
- Reset, then alloc_req=2'b11 for 16 cycles -> tags 32,33 ... 62,63 are issued in order. free_count reaches 0 and alloc_ready=0. A further alloc_req=2'b01 holds head.
- alloc_req=2'b10 right after reset -> alloc_tag[1]=32, alloc_tag[0]=0, free_count 32->31.
- From empty, commit_en=2'b11 with old tags 5,9 -> the next cycle alloc_req=2'b11 returns 5,9. In the same commit cycle alloc_ready stays 0 (no bypass).
- Allocate 6 tags and commit 2 (rhead=2). Then assert flush with commit_en=2'b01 (tag 7) in the same cycle -> head=3, the next alloc returns 35. free_count = DEPTH-3+3 = 32.
- Wrap: cycle enough alloc/release pairs to move all pointers past DEPTH twice -> tags are returned in FIFO order, and free_count never exceeds 32 or underflows.
- Assert rst during an alloc burst -> the next cycle free_count=32 and alloc_tag[0]=32.
